// File: rtl/hazard_ctrl_if.sv
// ID-stage hazard interface: the ID instruction descriptor, the memory freeze
// input, and the stall/bubble/counter outputs of the hazard controller.
interface hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic             id_valid_i;
    logic [4:0]       id_rs_i;
    logic [4:0]       id_rt_i;
    logic             id_use_rs_i;
    logic             id_use_rt_i;
    logic             id_branch_i;
    logic [4:0]       id_rd_i;
    logic             id_regw_i;
    logic             id_load_i;
    logic             mem_stall_i;
    logic             stall_o;
    logic             bubble_o;
    logic [CNT_W-1:0] stall_cnt_o;

    modport master (
        output id_valid_i, id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i,
               id_branch_i, id_rd_i, id_regw_i, id_load_i, mem_stall_i,
        input  stall_o, bubble_o, stall_cnt_o
    );

    modport slave (
        input  id_valid_i, id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i,
               id_branch_i, id_rd_i, id_regw_i, id_load_i, mem_stall_i,
        output stall_o, bubble_o, stall_cnt_o
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: tracks in-flight destination registers and decides
// ID-stage stalls, ID/EX bubble insertion and a saturating data-hazard stall counter.
module hazard_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    hazard_ctrl_if.slave  hz
);

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       regw;
        logic       load;
    } sb_entry_t;

    // The WB slot never produces a hazard (register file writes before it reads),
    // so only EX and MEM are held.
    sb_entry_t        ex_q, ex_d;
    sb_entry_t        mem_q, mem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic ex_hit;
    logic mem_hit;
    logic load_use;
    logic br_alu;
    logic br_mem;
    logic hazard;
    logic bubble;

    function automatic logic writes(input sb_entry_t e, input logic [4:0] r);
        return e.valid && e.regw && (e.rd == r) && (r != 5'd0);
    endfunction

    always_comb begin
        ex_hit  = hz.id_valid_i &&
                  ((hz.id_use_rs_i && writes(ex_q, hz.id_rs_i)) ||
                   (hz.id_use_rt_i && writes(ex_q, hz.id_rt_i)));
        mem_hit = hz.id_valid_i &&
                  ((hz.id_use_rs_i && writes(mem_q, hz.id_rs_i)) ||
                   (hz.id_use_rt_i && writes(mem_q, hz.id_rt_i)));

        load_use = ex_q.load && ex_hit;
        br_alu   = hz.id_branch_i && !ex_q.load && ex_hit;
        br_mem   = hz.id_branch_i && mem_q.load && mem_hit;
        hazard   = load_use || br_alu || br_mem;
        bubble   = hazard && !hz.mem_stall_i;
    end

    always_comb begin
        hz.stall_o     = hazard || hz.mem_stall_i;
        hz.bubble_o    = bubble;
        hz.stall_cnt_o = cnt_q;
    end

    always_comb begin
        ex_d  = ex_q;
        mem_d = mem_q;
        cnt_d = cnt_q;
        if (!hz.mem_stall_i) begin
            mem_d = ex_q;
            if (hazard) begin
                ex_d = '0;
            end else begin
                ex_d.valid = hz.id_valid_i;
                ex_d.rd    = hz.id_rd_i;
                ex_d.regw  = hz.id_regw_i;
                ex_d.load  = hz.id_load_i;
            end
        end
        if (bubble && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            ex_q  <= '0;
            mem_q <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vector table, a counter
// saturation sequence, and randomized traffic against a latency-based model.
module tb_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic       t_vld, t_urs, t_urt, t_br, t_regw, t_ld, t_ms;
    logic [4:0] t_rs, t_rt, t_rd;

    int unsigned checks = 0;
    int unsigned errors = 0;

    hazard_ctrl_if #(.CNT_W(16)) bus ();
    hazard_ctrl_if #(.CNT_W(2))  bus_s ();

    assign bus.id_valid_i    = t_vld;
    assign bus.id_rs_i       = t_rs;
    assign bus.id_rt_i       = t_rt;
    assign bus.id_use_rs_i   = t_urs;
    assign bus.id_use_rt_i   = t_urt;
    assign bus.id_branch_i   = t_br;
    assign bus.id_rd_i       = t_rd;
    assign bus.id_regw_i     = t_regw;
    assign bus.id_load_i     = t_ld;
    assign bus.mem_stall_i   = t_ms;
    assign bus_s.id_valid_i  = t_vld;
    assign bus_s.id_rs_i     = t_rs;
    assign bus_s.id_rt_i     = t_rt;
    assign bus_s.id_use_rs_i = t_urs;
    assign bus_s.id_use_rt_i = t_urt;
    assign bus_s.id_branch_i = t_br;
    assign bus_s.id_rd_i     = t_rd;
    assign bus_s.id_regw_i   = t_regw;
    assign bus_s.id_load_i   = t_ld;
    assign bus_s.mem_stall_i = t_ms;

    hazard_ctrl #(.CNT_W(16)) u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .hz    (bus)
    );

    hazard_ctrl #(.CNT_W(2)) u_dut_small (
        .clk_i (clk),
        .rst_i (rst),
        .hz    (bus_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        vld;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        urs;
        logic        urt;
        logic        br;
        logic [4:0]  rd;
        logic        regw;
        logic        ld;
        logic        ms;
        logic        e_stall;
        logic        e_bubble;
        int unsigned e_cnt;
    } vec_t;

    function automatic vec_t mk(bit r, bit vld, int rs, int rt, bit urs, bit urt, bit br,
                                int rd, bit regw, bit ld, bit ms,
                                bit es, bit eb, int unsigned ec);
        vec_t v;
        v.rst = r;   v.vld = vld; v.rs = 5'(rs); v.rt = 5'(rt);
        v.urs = urs; v.urt = urt; v.br = br;     v.rd = 5'(rd);
        v.regw = regw; v.ld = ld; v.ms = ms;
        v.e_stall = es; v.e_bubble = eb; v.e_cnt = ec;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(vec_t v);
        rst = v.rst;  t_vld = v.vld; t_rs = v.rs; t_rt = v.rt;
        t_urs = v.urs; t_urt = v.urt; t_br = v.br; t_rd = v.rd;
        t_regw = v.regw; t_ld = v.ld; t_ms = v.ms;
    endtask

    function automatic int unsigned sat(int unsigned n, int unsigned mx);
        return (n > mx) ? mx : n;
    endfunction

    // Drive one ID cycle away from the edge and check the combinational outputs
    // and the counter value accumulated by earlier edges.
    task automatic apply(vec_t v, string tag);
        @(negedge clk);
        drive(v);
        #1;
        check({tag, "_stall"},  32'(bus.stall_o),        32'(v.e_stall));
        check({tag, "_bubble"}, 32'(bus.bubble_o),       32'(v.e_bubble));
        check({tag, "_cnt"},    32'(bus.stall_cnt_o),    v.e_cnt);
        check({tag, "_cnt2"},   32'(bus_s.stall_cnt_o),  sat(v.e_cnt, 3));
    endtask

    // Behavioural model: producers listed newest first; a consumer may not start
    // until the producer is far enough ahead for its result to be forwardable.
    typedef struct {
        bit       v;
        bit [4:0] rd;
        bit       regw;
        bit       load;
    } prod_t;

    prod_t       flight[$];
    int unsigned m_cnt;

    function automatic bit model_hazard();
        bit need;
        int unsigned req;
        foreach (flight[i]) begin
            if (!flight[i].v || !flight[i].regw || flight[i].rd == 5'd0) continue;
            need = t_vld && ((t_urs && t_rs == flight[i].rd) || (t_urt && t_rt == flight[i].rd));
            if (!need) continue;
            if (flight[i].load) req = t_br ? 3 : 2;
            else                req = t_br ? 2 : 1;
            if (32'(i) + 1 < req) return 1'b1;
        end
        return 1'b0;
    endfunction

    vec_t tbl[$];

    initial begin
        vec_t  idle, lw8, add9;
        bit    hz_m;
        prod_t p;

        idle = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(idle);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        //            rst vld rs  rt urs urt br rd regw ld ms  es eb cnt
        tbl.push_back(mk(1, 1, 29, 0, 1, 0, 0,  8, 1, 1, 0, 0, 0, 0)); // lw $8
        tbl.push_back(mk(1, 1,  8,10, 1, 1, 0,  9, 1, 0, 0, 1, 1, 0)); // add $9,$8,$10
        tbl.push_back(mk(1, 1,  8,10, 1, 1, 0,  9, 1, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 29, 0, 1, 0, 0,  8, 1, 1, 0, 0, 0, 1)); // lw $8
        tbl.push_back(mk(1, 1,  8, 0, 1, 1, 1,  0, 0, 0, 0, 1, 1, 1)); // beq $8,$0
        tbl.push_back(mk(1, 1,  8, 0, 1, 1, 1,  0, 0, 0, 0, 1, 1, 2));
        tbl.push_back(mk(1, 1,  8, 0, 1, 1, 1,  0, 0, 0, 0, 0, 0, 3));
        tbl.push_back(mk(1, 1,  1, 2, 1, 1, 0,  0, 1, 0, 0, 0, 0, 3)); // add $0
        tbl.push_back(mk(1, 1,  0, 0, 1, 1, 1,  0, 0, 0, 0, 0, 0, 3)); // beq $0,$0
        tbl.push_back(mk(1, 1, 29, 0, 1, 0, 0,  0, 1, 1, 0, 0, 0, 3)); // lw $0
        tbl.push_back(mk(1, 1,  0, 0, 1, 1, 0,  3, 1, 0, 0, 0, 0, 3)); // add $3,$0,$0
        tbl.push_back(mk(1, 1, 29, 0, 1, 0, 0,  8, 1, 1, 0, 0, 0, 3)); // lw $8
        tbl.push_back(mk(1, 1,  8,10, 1, 1, 0,  9, 1, 0, 1, 1, 0, 3)); // use under mem stall
        tbl.push_back(mk(1, 1,  8,10, 1, 1, 0,  9, 1, 0, 1, 1, 0, 3));
        tbl.push_back(mk(1, 1,  8,10, 1, 1, 0,  9, 1, 0, 1, 1, 0, 3));
        tbl.push_back(mk(1, 1,  8,10, 1, 1, 0,  9, 1, 0, 0, 1, 1, 3));
        tbl.push_back(mk(1, 1,  8,10, 1, 1, 0,  9, 1, 0, 0, 0, 0, 4));
        tbl.push_back(mk(1, 1,  1, 2, 1, 1, 0,  5, 1, 0, 0, 0, 0, 4)); // add $5
        tbl.push_back(mk(1, 1,  5, 6, 1, 1, 1,  0, 0, 0, 0, 1, 1, 4)); // bne $5,$6
        tbl.push_back(mk(1, 1,  5, 6, 1, 1, 1,  0, 0, 0, 0, 0, 0, 5));
        tbl.push_back(mk(1, 1, 29, 0, 1, 0, 0,  7, 1, 1, 0, 0, 0, 5)); // lw $7
        tbl.push_back(mk(1, 1,  1, 2, 1, 1, 0, 11, 1, 0, 0, 0, 0, 5)); // independent add
        tbl.push_back(mk(1, 1,  7, 0, 1, 1, 1,  0, 0, 0, 0, 1, 1, 5)); // beq $7,$0
        tbl.push_back(mk(1, 1,  7, 0, 1, 1, 1,  0, 0, 0, 0, 0, 0, 6));
        tbl.push_back(mk(1, 1, 29, 0, 1, 0, 0, 12, 1, 1, 0, 0, 0, 6)); // lw $12
        tbl.push_back(mk(1, 0, 12, 0, 1, 0, 0, 12, 1, 1, 0, 0, 0, 6)); // flushed slot
        tbl.push_back(mk(1, 1, 12, 0, 1, 0, 0, 13, 1, 0, 0, 0, 0, 6)); // use $12
        tbl.push_back(mk(1, 1, 29, 0, 1, 0, 0,  8, 1, 1, 0, 0, 0, 6)); // lw $8
        tbl.push_back(mk(0, 1,  8, 0, 1, 1, 1,  0, 0, 0, 0, 1, 1, 6)); // beq + reset
        tbl.push_back(mk(1, 1,  8, 0, 1, 1, 1,  0, 0, 0, 0, 0, 0, 0));

        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // Saturation: five load-use stalls on a 2-bit counter.
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "sat_rst");
        for (int unsigned k = 0; k < 5; k++) begin
            lw8  = mk(1, 1, 29, 0, 1, 0, 0, 8, 1, 1, 0, 0, 0, k);
            add9 = mk(1, 1,  8, 10, 1, 1, 0, 9, 1, 0, 0, 1, 1, k);
            apply(lw8,  $sformatf("sat%0d_lw", k));
            apply(add9, $sformatf("sat%0d_stall", k));
            add9.e_stall = 1'b0; add9.e_bubble = 1'b0; add9.e_cnt = k + 1;
            apply(add9, $sformatf("sat%0d_go", k));
        end
        check("sat_final_small", 32'(bus_s.stall_cnt_o), 3);
        check("sat_final_wide",  32'(bus.stall_cnt_o),   5);

        // Randomized traffic against the model, starting from a reset edge.
        @(negedge clk);
        drive(idle);
        rst = 1'b0;
        @(posedge clk);
        flight.delete();
        m_cnt = 0;
        for (int unsigned n = 0; n < 3000; n++) begin
            @(negedge clk);
            rst    = ($urandom_range(63) != 0);
            t_vld  = ($urandom_range(7) != 0);
            t_rs   = 5'($urandom_range(3));
            t_rt   = 5'($urandom_range(3));
            t_urs  = $urandom_range(1) != 0;
            t_urt  = $urandom_range(1) != 0;
            t_br   = ($urandom_range(3) == 0);
            t_rd   = 5'($urandom_range(3));
            t_regw = ($urandom_range(3) != 0);
            t_ld   = ($urandom_range(2) == 0);
            t_ms   = ($urandom_range(4) == 0);
            #1;
            hz_m = model_hazard();
            check("rnd_stall",  32'(bus.stall_o),       32'(hz_m | t_ms));
            check("rnd_bubble", 32'(bus.bubble_o),      32'(hz_m & !t_ms));
            check("rnd_cnt",    32'(bus.stall_cnt_o),   sat(m_cnt, 65535));
            check("rnd_cnt2",   32'(bus_s.stall_cnt_o), sat(m_cnt, 3));
            @(posedge clk);
            if (!rst) begin
                flight.delete();
                m_cnt = 0;
            end else if (!t_ms) begin
                if (hz_m) begin
                    m_cnt++;
                    p = '{v: 1'b0, rd: 5'd0, regw: 1'b0, load: 1'b0};
                end else begin
                    p = '{v: t_vld, rd: t_rd, regw: t_regw, load: t_ld};
                end
                flight.push_front(p);
                if (flight.size() > 3) void'(flight.pop_back());
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
